dm_load_unit: RTL and testbench

Read-side companion to the data memory's sub-word store path.
- Accepts load requests from the CPU datapath over a valid/ready handshake.
- Fetches the containing 32-bit word from data memory over a word-indexed read port with configurable read latency.
- Returns byte, halfword or word results, sign- or zero-extended, with a misalignment error flag, over a valid/ready response handshake.
- Sits between the MEM stage and the data memory read port.

---
 rtl/dm_load_unit.sv | 150 +++++++++++++++
 tb/tb_dm_load_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_load_unit.sv
`default_nettype none
// ============================================================================
// dm_load_unit : data-memory load path (fetch word, extract, extend, respond)
// Rev 1.0
// ============================================================================
module dm_load_unit #(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_memop,
  input  logic              req_unsigned,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] c_LAT = 2'(RD_LAT);

  state_t              r_state;
  logic                r_req_ready;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_resp_valid;
  logic [31:0]         r_resp_data;
  logic                r_resp_err;
  logic [1:0]          r_cnt;
  logic [1:0]          r_off;
  logic [1:0]          r_memop;
  logic                r_unsigned;

  logic                w_misaligned;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_ext;
  logic                w_unused_addr;

  // Upper address bits wrap modulo the memory size.
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  always_comb begin
    w_misaligned = 1'b0;
    case (req_memop)
      2'b01:   w_misaligned = 1'b0;
      2'b10:   w_misaligned = req_addr[0];
      default: w_misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_off)
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_memop)
      2'b01:   w_ext = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      2'b10:   w_ext = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_cnt        <= 2'd0;
      r_off        <= 2'd0;
      r_memop      <= 2'd0;
      r_unsigned   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_off       <= req_addr[1:0];
            r_memop     <= req_memop;
            r_unsigned  <= req_unsigned;
            r_mem_addr  <= req_addr[ADDR_W+1:2];
            r_req_ready <= 1'b0;
            if (w_misaligned) begin
              // Faulting loads never touch memory.
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= '0;
            end else begin
              r_state  <= ST_WAIT;
              r_mem_rd <= 1'b1;
              r_cnt    <= 2'd0;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == c_LAT) begin
            r_state      <= ST_RESP;
            r_mem_rd     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_ext;
            r_resp_err   <= 1'b0;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_mem_rd     <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_mem_addr;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_dm_load_unit.sv
`default_nettype none
// ============================================================================
// tb_dm_load_unit : three instances (RD_LAT 0/1/3) against a memory + load model
// Rev 1.0
// ============================================================================
module tb_dm_load_unit;

  logic        clk;
  logic        rstn;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_memop;
  logic        req_unsigned;
  logic [2:0]  mem_rd;
  logic [6:0]  mem_addr [3];
  logic [2:0]  resp_valid;
  logic [2:0]  resp_ready;
  logic [31:0] resp_data [3];
  logic [2:0]  resp_err;

  logic [31:0] mem [128];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [6:0]  a_d1, a_d2, a_d3;
    logic        rd_d1, rd_d2, rd_d3;
    logic [31:0] rdata;

    // Memory returns the addressed word L cycles after the strobe, junk otherwise.
    always_ff @(posedge clk) begin
      a_d1  <= mem_addr[g];
      a_d2  <= a_d1;
      a_d3  <= a_d2;
      rd_d1 <= mem_rd[g];
      rd_d2 <= rd_d1;
      rd_d3 <= rd_d2;
    end

    always_comb begin
      rdata = 32'hDEAD_BEEF;
      if (L == 0) begin
        if (mem_rd[g]) rdata = mem[mem_addr[g]];
      end else if (L == 1) begin
        if (rd_d1) rdata = mem[a_d1];
      end else begin
        if (rd_d3) rdata = mem[a_d3];
      end
    end

    dm_load_unit #(.ADDR_W(7), .RD_LAT(L)) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_addr     (req_addr),
      .req_memop    (req_memop),
      .req_unsigned (req_unsigned),
      .mem_rd       (mem_rd[g]),
      .mem_addr     (mem_addr[g]),
      .mem_rdata    (rdata),
      .resp_valid   (resp_valid[g]),
      .resp_ready   (resp_ready[g]),
      .resp_data    (resp_data[g]),
      .resp_err     (resp_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] op);
    if (op == 2'b01) return 1'b0;
    if (op == 2'b10) return (int'(off) % 2) != 0;
    return off != 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] op, input logic uns);
    longint v;
    int     bits;
    if (op == 2'b01)      bits = 8;
    else if (op == 2'b10) bits = 16;
    else                  return w;
    v = longint'(w >> (8 * int'(off))) % (longint'(1) << bits);
    if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  task automatic do_load(input int k, input logic [31:0] addr, input logic [1:0] op,
                         input logic uns, input int hold, input string tag);
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    logic        saw_rd;
    logic [31:0] held;
    exp_e   = is_misaligned(addr[1:0], op);
    exp_d   = exp_e ? 32'd0 : ref_load(mem[addr[8:2]], addr[1:0], op, uns);
    exp_lat = exp_e ? 0 : lat_of(k) + 1;

    @(negedge clk);
    req_addr     = addr;
    req_memop    = op;
    req_unsigned = uns;
    req_valid[k] = 1'b1;
    check({tag, ":req_ready"}, {31'd0, req_ready[k]}, 32'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_addr     = $urandom;
    if (exp_e) check({tag, ":no_mem_rd"}, {31'd0, mem_rd[k]}, 32'd0);
    else       check({tag, ":mem_addr"}, {25'd0, mem_addr[k]}, {25'd0, addr[8:2]});
    lat    = 0;
    saw_rd = 1'b0;
    while (!resp_valid[k] && lat < 12) begin
      saw_rd = saw_rd | mem_rd[k];
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":data"}, resp_data[k], exp_d);
    check({tag, ":err"}, {31'd0, resp_err[k]}, {31'd0, exp_e});
    if (exp_e) check({tag, ":rd_seen"}, {31'd0, saw_rd}, 32'd0);

    if (hold > 0) begin
      held         = resp_data[k];
      req_valid[k] = 1'b1;
      req_addr     = $urandom;
      req_memop    = 2'(($urandom_range(0, 3)));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, ":bp_valid"}, {31'd0, resp_valid[k]}, 32'd1);
        check({tag, ":bp_data"}, resp_data[k], held);
        check({tag, ":bp_ready"}, {31'd0, req_ready[k]}, 32'd0);
      end
    end
    @(negedge clk);
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    req_valid[k]  = 1'b0;
    check({tag, ":idle_ready"}, {31'd0, req_ready[k]}, 32'd1);
    check({tag, ":idle_valid"}, {31'd0, resp_valid[k]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        any_v;
    rstn         = 1'b0;
    req_valid    = '0;
    resp_ready   = '0;
    req_addr     = '0;
    req_memop    = '0;
    req_unsigned = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[3] = 32'h8765_43A1;
    mem[0] = 32'h0000_FF80;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_req_ready", {31'd0, req_ready[k]}, 32'd1);
      check("rst_mem_rd", {31'd0, mem_rd[k]}, 32'd0);
      check("rst_mem_addr", {25'd0, mem_addr[k]}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid[k]}, 32'd0);
      check("rst_resp_data", resp_data[k], 32'd0);
      check("rst_resp_err", {31'd0, resp_err[k]}, 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // Directed loads on the RD_LAT=1 instance.
    do_load(1, 32'h0000_000C, 2'b01, 1'b0, 0, "byteC_s");
    do_load(1, 32'h0000_000D, 2'b01, 1'b1, 0, "byteD_u");
    do_load(1, 32'h0000_000E, 2'b10, 1'b0, 0, "halfE_s");
    do_load(1, 32'h0000_000E, 2'b10, 1'b1, 0, "halfE_u");
    do_load(1, 32'h0000_000C, 2'b00, 1'b0, 0, "wordC");
    do_load(1, 32'h0000_000C, 2'b11, 1'b1, 0, "wordC_11");
    do_load(1, 32'h0000_000D, 2'b00, 1'b0, 0, "word_mis");
    do_load(1, 32'h0000_000F, 2'b10, 1'b0, 0, "half_mis");
    do_load(1, 32'h0000_000C, 2'b01, 1'b0, 5, "backpress");
    do_load(1, 32'hFFFF_FE0C, 2'b00, 1'b0, 0, "wrap");
    do_load(0, 32'h0000_0000, 2'b01, 1'b0, 0, "lat0_byte");
    do_load(2, 32'h0000_0000, 2'b01, 1'b0, 0, "lat3_byte");

    // Reset during WAIT drops the pending load.
    @(negedge clk);
    req_addr     = 32'h0000_000C;
    req_memop    = 2'b00;
    req_unsigned = 1'b0;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("wait_rst_ready", {31'd0, req_ready[1]}, 32'd1);
    check("wait_rst_mem_rd", {31'd0, mem_rd[1]}, 32'd0);
    check("wait_rst_valid", {31'd0, resp_valid[1]}, 32'd0);
    @(negedge clk);
    rstn  = 1'b1;
    any_v = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      any_v = any_v | resp_valid[1];
    end
    check("wait_rst_no_resp", {31'd0, any_v}, 32'd0);
    do_load(1, 32'h0000_000E, 2'b10, 1'b0, 0, "after_rst");

    // Randomized loads on every latency.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 30; n++) begin
        a = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 127)) << 2)
            | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) mem[a[8:2]] = $urandom;
        do_load(k, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
